// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed immediate into the immediate fields of a RISC-V
// instruction word (bits [31:7]). It takes the non-immediate fields from
// 'base' and flags immediates that do not fit the selected format.
// Each result is registered behind a one-deep valid/ready output stage.
// A saturating counter tracks how many accepted requests were flagged.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload steady while valid && !ready.
// in_ready = !out_valid || out_ready, so the block can take a new request in
// the same cycle that the consumer drains the current result. This gives
// back-to-back results with no bubble.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [24:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SRA   = 3'b101;
  localparam logic [2:0] SRC_SHIFT = 3'b110;

  logic        accept;
  logic [24:0] enc_data;
  logic        enc_err;

  // Range checks. The I/S/B/J immediates are sign-extended from their top
  // bit, so every bit above that position must match it.
  logic fits_12;  // imm[31:11] all equal
  logic fits_13;  // imm[31:12] all equal
  logic fits_21;  // imm[31:20] all equal
  logic fits_sh;  // shift amount fits in 5 unsigned bits

  assign fits_12 = (&imm[31:11]) || (~|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || (~|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || (~|imm[31:20]);
  assign fits_sh = ~|imm[31:5];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Scatter the immediate into the per-format field layout. Fields are still
  // written, truncated, when the range check fails.
  always_comb begin
    enc_data = base;
    enc_err  = 1'b0;
    case (imm_src)
      SRC_I: begin
        enc_data[24:13] = imm[11:0];
        enc_err         = !fits_12;
      end
      SRC_S: begin
        enc_data[24:18] = imm[11:5];
        enc_data[4:0]   = imm[4:0];
        enc_err         = !fits_12;
      end
      SRC_B: begin
        enc_data[24]    = imm[12];
        enc_data[23:18] = imm[10:5];
        enc_data[4:1]   = imm[4:1];
        enc_data[0]     = imm[11];
        enc_err         = !fits_13 || imm[0];
      end
      SRC_J: begin
        enc_data[24]    = imm[20];
        enc_data[23:14] = imm[10:1];
        enc_data[13]    = imm[11];
        enc_data[12:5]  = imm[19:12];
        enc_err         = !fits_21 || imm[0];
      end
      SRC_U: begin
        enc_data[24:5]  = imm[31:12];
        enc_err         = |imm[11:0];
      end
      SRC_SRA, SRC_SHIFT: begin
        // funct7 (bits [24:18]) stays as supplied in base, which tells the
        // arithmetic shift apart from the logical one.
        enc_data[17:13] = imm[4:0];
        enc_err         = !fits_sh;
      end
      default: begin
        // Invalid format code: base passes through untouched.
        enc_data = base;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register and error counter. Reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 25'd0;
      out_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= enc_data;
        out_err   <= enc_err;
        if (enc_err && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors for imm_encoder with hand-computed
// expected encodings, a backpressure sequence checked through an expected
// queue, and an error-counter saturation / mid-stream reset sequence.
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm;
  logic [24:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  logic        sb_en = 1'b0;
  logic [25:0] exp_q[$];
  logic [25:0] exp_item;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_src   (imm_src),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pops one expected {err,data} for every output transfer.
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_item = exp_q.pop_front();
        check("sb_data", 32'({out_err, out_data}), 32'(exp_item));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One request with an always-ready consumer. Checks the result one cycle
  // later, then checks that the output stage empties.
  task automatic send_one(input string tag, input logic [2:0] src, input logic [31:0] v,
                          input logic [24:0] b, input logic [24:0] exp_data, input logic exp_err);
    imm_src   = src;
    imm       = v;
    base      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_err && exp_cnt != 255) exp_cnt++;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(exp_data));
    check({tag, "_err"},   32'(out_err),   32'(exp_err));
    check({tag, "_cnt"},   32'(err_cnt),   32'(exp_cnt));
    @(posedge clk); #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    imm_src   = 3'b000;
    imm       = 32'd0;
    base      = 25'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    check("rst_cnt",   32'(err_cnt),   32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed format vectors
    send_one("i_neg1",    3'b000, 32'hFFFF_FFFF, 25'h0000000, 25'h1FFE000, 1'b0);
    send_one("u_basic",   3'b100, 32'h1234_5000, 25'h000001F, 25'h02468BF, 1'b0);
    send_one("b_odd",     3'b010, 32'h0000_0801, 25'h0000000, 25'h0000001, 1'b1);
    send_one("b_min",     3'b010, 32'hFFFF_F000, 25'h0000000, 25'h1000000, 1'b0);
    send_one("j_max",     3'b011, 32'h000F_FFFE, 25'h0000000, 25'h0FFFFE0, 1'b0);
    send_one("j_over",    3'b011, 32'h0010_0000, 25'h0000000, 25'h1000000, 1'b1);
    send_one("j_min",     3'b011, 32'hFFF0_0000, 25'h0000000, 25'h1000000, 1'b0);
    send_one("s_neg4",    3'b001, 32'hFFFF_FFFC, 25'h1FFFFFF, 25'h1FFFFFC, 1'b0);
    send_one("i_over",    3'b000, 32'h0000_0800, 25'h0001FFF, 25'h1001FFF, 1'b1);
    send_one("sra_5",     3'b101, 32'h0000_0005, 25'h1FFFFFF, 25'h1FCBFFF, 1'b0);
    send_one("sh_over",   3'b110, 32'h0000_0020, 25'h0000000, 25'h0000000, 1'b1);
    send_one("invalid",   3'b111, 32'h0000_0000, 25'h0123456, 25'h0123456, 1'b1);
    send_one("u_low",     3'b100, 32'hFFFF_F001, 25'h0000000, 25'h1FFFFE0, 1'b1);

    // Backpressure: A accepted, consumer stalls 3 cycles while B waits
    sb_en     = 1'b1;
    imm_src   = 3'b000;
    base      = 25'd0;
    imm       = 32'd1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 25'h0002000});
    @(posedge clk); #1;
    check("bp_a_valid", 32'(out_valid), 32'd1);
    imm = 32'd2;
    exp_q.push_back({1'b0, 25'h0004000});
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_data",  32'(out_data),  32'h0002000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_data",  32'(out_data),  32'h0004000);
    imm = 32'd3;
    exp_q.push_back({1'b0, 25'h0006000});
    @(posedge clk); #1;
    check("bp_c_valid", 32'(out_valid), 32'd1);
    check("bp_c_data",  32'(out_data),  32'h0006000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;

    // Saturation: 300 invalid-code requests, then reset mid-stream
    imm_src   = 3'b111;
    imm       = 32'd0;
    base      = 25'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("sat_cnt", 32'(err_cnt), 32'd255);
    check("sat_err", 32'(out_err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_err",   32'(out_err),   32'd0);
    check("mid_rst_cnt",   32'(err_cnt),   32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_cnt",   32'(err_cnt),   32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
